// File: rtl/dev_opm_dac.sv
// dev_opm_dac
//   Receiving end of the OPM serial DAC link (SO/SH1/SH2), decoding the
//   13-bit floating-point sample stream of a YM3012-style DAC into signed
//   16-bit left/right PCM for the audio mixer. One instance per OPM core.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   ce         shift enable, one clk wide, at the OPM phi1 rate
//   so         serial data from the OPM, LSB first
//   sh1        left-channel sample-hold strobe (latches on falling edge)
//   sh2        right-channel sample-hold strobe (latches on falling edge)
//   sample_L   signed left sample
//   sample_R   signed right sample
//   stb_L      one-clk pulse when sample_L has been updated
//   stb_R      one-clk pulse when sample_R has been updated
//   frame_err  one-clk pulse when an SH edge arrives after fewer than 16 bits
//   active     high while SH edges keep arriving within TIMEOUT ce ticks
//
// Parameters
//   TIMEOUT    ce ticks without any SH falling edge before outputs are muted

module dev_opm_dac #(
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               so,
  input  logic               sh1,
  input  logic               sh2,
  output logic signed [15:0] sample_L,
  output logic signed [15:0] sample_R,
  output logic               stb_L,
  output logic               stb_R,
  output logic               frame_err,
  output logic               active
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  // Only the 12 most recent bits are stored. Together with the bit arriving
  // on the edge clk they form word bits w[15:3]; the three low bits of a
  // 16-bit word are never decoded, so they are simply allowed to fall off.
  logic [11:0]    sr;
  logic [4:0]     cnt;
  logic           sh1_q;
  logic           sh2_q;
  logic [WDW-1:0] wd;

  logic [4:0]         cnt_post;
  logic               fall1;
  logic               fall2;
  logic               any_fall;
  logic               full;
  logic [2:0]         expo;
  logic [9:0]         mant;
  logic [2:0]         shamt;
  logic signed [15:0] mant_ext;
  logic signed [15:0] shifted;
  logic signed [15:0] result;

  // Edge detection, bit counting and the floating-point decode of the
  // post-shift word {so, sr}. The mantissa is offset binary, so inverting
  // D9 turns it into a 10-bit two's-complement value.
  always_comb begin
    cnt_post = (cnt == 5'd31) ? 5'd31 : cnt + 5'd1;
    fall1    = sh1_q & ~sh1;
    fall2    = sh2_q & ~sh2;
    any_fall = fall1 | fall2;
    full     = cnt_post >= 5'd16;
    expo     = {so, sr[11:10]};
    mant     = {~sr[9], sr[8:0]};
    mant_ext = $signed({{6{mant[9]}}, mant});
    shamt    = expo - 3'd1;
    shifted  = mant_ext <<< shamt;
    result   = (expo == 3'd0) ? 16'sd0 : shifted;
  end

  // Strobes are single-clk pulses regardless of ce; everything else only
  // moves on ce. Any SH falling edge restarts the bit count and the
  // watchdog, whether or not the frame was long enough to latch. The
  // watchdog mutes the outputs once, on the tick that reaches TIMEOUT,
  // and then holds saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      sh1_q     <= 1'b0;
      sh2_q     <= 1'b0;
      wd        <= '0;
      sample_L  <= '0;
      sample_R  <= '0;
      stb_L     <= 1'b0;
      stb_R     <= 1'b0;
      frame_err <= 1'b0;
      active    <= 1'b0;
    end else begin
      stb_L     <= 1'b0;
      stb_R     <= 1'b0;
      frame_err <= 1'b0;
      if (ce) begin
        sr    <= {so, sr[11:1]};
        sh1_q <= sh1;
        sh2_q <= sh2;
        if (any_fall) begin
          cnt    <= '0;
          wd     <= '0;
          active <= 1'b1;
          if (full) begin
            if (fall1) begin
              sample_L <= result;
              stb_L    <= 1'b1;
            end
            if (fall2) begin
              sample_R <= result;
              stb_R    <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          cnt <= cnt_post;
          if (wd == WD_LAST) begin
            wd       <= WD_MAX;
            active   <= 1'b0;
            sample_L <= '0;
            sample_R <= '0;
          end else if (wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dev_opm_dac.sv
// tb_dev_opm_dac
//   Self-checking bench for dev_opm_dac. A main instance uses the default
//   TIMEOUT; a second instance with TIMEOUT=8 shares the inputs and is used
//   for the short watchdog scenario. Expected samples come from a plain
//   arithmetic model: (D - 512) * 2^(E-1), or 0 when E is 0.

module tb_dev_opm_dac;

  logic clk = 1'b0;
  logic reset, ce, so, sh1, sh2;
  logic signed [15:0] sample_L, sample_R, sample_L_8, sample_R_8;
  logic stb_L, stb_R, frame_err, active;
  logic stb_L_8, stb_R_8, frame_err_8, active_8;

  int checks = 0;
  int errors = 0;
  int bits_since = 0;
  logic signed [15:0] exp_L = '0;
  logic signed [15:0] exp_R = '0;

  dev_opm_dac dut (
    .clk(clk), .reset(reset), .ce(ce), .so(so), .sh1(sh1), .sh2(sh2),
    .sample_L(sample_L), .sample_R(sample_R), .stb_L(stb_L), .stb_R(stb_R),
    .frame_err(frame_err), .active(active)
  );

  dev_opm_dac #(.TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .ce(ce), .so(so), .sh1(sh1), .sh2(sh2),
    .sample_L(sample_L_8), .sample_R(sample_R_8), .stb_L(stb_L_8), .stb_R(stb_R_8),
    .frame_err(frame_err_8), .active(active_8)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout simulation did not finish in time");
    $fatal(1, "[TB] stuck");
  end

  function automatic logic signed [15:0] ref_val(input logic [15:0] w);
    int e, d, v;
    e = int'(w[15:13]);
    d = int'(w[12:3]);
    if (e == 0) v = 0;
    else v = (d - 512) * (1 << (e - 1));
    return 16'(v);
  endfunction

  function automatic logic [15:0] mk(input int e, input int d, input int dummy);
    logic [15:0] w;
    w = {3'(e), 10'(d), 3'(dummy)};
    return w;
  endfunction

  // One ce tick carrying bit b with the given SH levels; returns at the
  // falling edge after the ce clk, where that tick's results are visible.
  task automatic tick(input logic b, input logic s1, input logic s2);
    @(negedge clk);
    so = b; sh1 = s1; sh2 = s2; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    bits_since++;
  endtask

  // Sends n bits of w LSB first, with the selected SH lines falling on the
  // last bit, and checks the latch result and the strobe clearing.
  task automatic send_frame(input logic [15:0] w, input int n, input bit f1,
                            input bit f2, input string name);
    bit valid;
    for (int i = 0; i < n - 1; i++) tick(w[i], 1'b1, 1'b1);
    tick(w[n-1], !f1, !f2);
    valid = bits_since >= 16;
    bits_since = 0;
    if (valid && f1) exp_L = ref_val(w);
    if (valid && f2) exp_R = ref_val(w);
    checks++; if (stb_L !== (f1 && valid)) begin errors++; $display("[TB] FAIL %s stb_L got %b want %b", name, stb_L, f1 && valid); end
    checks++; if (stb_R !== (f2 && valid)) begin errors++; $display("[TB] FAIL %s stb_R got %b want %b", name, stb_R, f2 && valid); end
    checks++; if (frame_err !== !valid) begin errors++; $display("[TB] FAIL %s frame_err got %b want %b", name, frame_err, !valid); end
    checks++; if (sample_L !== exp_L) begin errors++; $display("[TB] FAIL %s sample_L got %0d want %0d", name, sample_L, exp_L); end
    checks++; if (sample_R !== exp_R) begin errors++; $display("[TB] FAIL %s sample_R got %0d want %0d", name, sample_R, exp_R); end
    checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL %s active got %b want 1", name, active); end
    @(negedge clk);
    checks++; if ({stb_L, stb_R, frame_err} !== 3'b000) begin errors++; $display("[TB] FAIL %s pulse_clear got %b want 000", name, {stb_L, stb_R, frame_err}); end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b0; so = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({sample_L, sample_R} !== 32'd0) begin errors++; $display("[TB] FAIL reset samples got %h want 0", {sample_L, sample_R}); end
    checks++; if ({stb_L, stb_R, frame_err, active} !== 4'b0) begin errors++; $display("[TB] FAIL reset flags got %b want 0000", {stb_L, stb_R, frame_err, active}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    send_frame(mk(7, 10'h3FF, 0), 16, 1, 0, "max_left");
    checks++; if (exp_L !== 16'sd32704 || sample_L !== 16'sd32704) begin errors++; $display("[TB] FAIL max_left_value got %0d want 32704", sample_L); end
    send_frame(mk(7, 0, 5), 16, 0, 1, "min_right");
    checks++; if (sample_R !== -16'sd32768) begin errors++; $display("[TB] FAIL min_right_value got %0d want -32768", sample_R); end
    send_frame(mk(1, 10'h201, 2), 16, 1, 0, "small_one");
    checks++; if (sample_L !== 16'sd1) begin errors++; $display("[TB] FAIL small_one_value got %0d want 1", sample_L); end
    send_frame(mk(0, 10'h201, 2), 16, 1, 0, "zero_exp");
    checks++; if (sample_L !== 16'sd0) begin errors++; $display("[TB] FAIL zero_exp_value got %0d want 0", sample_L); end
    send_frame(mk(7, 10'h155, 0), 10, 1, 0, "short_frame");
    send_frame(mk(3, 10'h0F0, 1), 16, 1, 0, "after_short");
    send_frame(mk(2, 10'h300, 0), 16, 1, 1, "both_edges");
    checks++; if (sample_L !== 16'sd512 || sample_R !== 16'sd512) begin errors++; $display("[TB] FAIL both_edges_value got %0d/%0d want 512/512", sample_L, sample_R); end
  endtask

  task automatic test_held();
    for (int i = 0; i < 40; i++) begin
      tick(1'($urandom), (i >= 20), (i >= 20));
      checks++; if ({stb_L, stb_R, frame_err} !== 3'b000) begin errors++; $display("[TB] FAIL held_sh tick %0d flags got %b want 000", i, {stb_L, stb_R, frame_err}); end
    end
    checks++; if (sample_L !== exp_L || sample_R !== exp_R) begin errors++; $display("[TB] FAIL held_sh samples got %0d/%0d want %0d/%0d", sample_L, sample_R, exp_L, exp_R); end
    send_frame(mk(5, 10'h2AA, 3), 16, 0, 1, "after_held");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int ch, n;
      logic [15:0] w;
      w = 16'($urandom);
      ch = $urandom_range(1, 3);
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 15) : 16;
      send_frame(w, n, ch[0], ch[1], "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(mk(6, 10'h123, 0), 16, 1, 0, "b2b_a");
    send_frame(mk(4, 10'h3C0, 7), 16, 0, 1, "b2b_b");
    send_frame(mk(7, 10'h001, 4), 16, 1, 1, "b2b_c");
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    w = mk(7, 10'h3F0, 0);
    send_frame(mk(6, 10'h3FF, 0), 16, 1, 1, "pre_reset");
    for (int i = 0; i < 8; i++) tick(w[i], 1'b1, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({sample_L, sample_R, sample_L_8, sample_R_8} !== 64'd0) begin errors++; $display("[TB] FAIL async_reset samples got %h want 0", {sample_L, sample_R}); end
    checks++; if ({stb_L, stb_R, frame_err, active, active_8} !== 5'b0) begin errors++; $display("[TB] FAIL async_reset flags got %b want 0", {stb_L, stb_R, frame_err, active}); end
    @(negedge clk);
    reset = 1'b0;
    exp_L = '0; exp_R = '0; bits_since = 0;
    send_frame(w >> 8, 8, 1, 0, "post_reset_partial");
    send_frame(w, 16, 1, 0, "post_reset_full");
  endtask

  task automatic test_timeout();
    send_frame(mk(7, 10'h2C0, 0), 16, 1, 0, "wd_start");
    checks++; if (active_8 !== 1'b1 || sample_L_8 !== exp_L) begin errors++; $display("[TB] FAIL wd8_start got %b/%0d want 1/%0d", active_8, sample_L_8, exp_L); end
    for (int i = 0; i < 7; i++) tick(1'($urandom), 1'b1, 1'b1);
    checks++; if (active_8 !== 1'b1 || sample_L_8 !== exp_L) begin errors++; $display("[TB] FAIL wd8_before got %b/%0d want 1/%0d", active_8, sample_L_8, exp_L); end
    tick(1'b1, 1'b1, 1'b1);
    checks++; if (active_8 !== 1'b0) begin errors++; $display("[TB] FAIL wd8_active got %b want 0", active_8); end
    checks++; if (sample_L_8 !== 16'sd0 || sample_R_8 !== 16'sd0) begin errors++; $display("[TB] FAIL wd8_mute got %0d/%0d want 0/0", sample_L_8, sample_R_8); end
    checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL wd_main_early got %b want 1", active); end
    send_frame(mk(7, 10'h3FF, 0), 16, 1, 0, "wd_restore");
    checks++; if (active_8 !== 1'b1 || sample_L_8 !== 16'sd32704) begin errors++; $display("[TB] FAIL wd8_restore got %b/%0d want 1/32704", active_8, sample_L_8); end
    for (int i = 0; i < 1023; i++) tick(1'($urandom), 1'b1, 1'b1);
    checks++; if (active !== 1'b1 || sample_L !== exp_L) begin errors++; $display("[TB] FAIL wd_main_before got %b/%0d want 1/%0d", active, sample_L, exp_L); end
    tick(1'b0, 1'b1, 1'b1);
    exp_L = '0; exp_R = '0;
    checks++; if (active !== 1'b0 || sample_L !== 16'sd0 || sample_R !== 16'sd0) begin errors++; $display("[TB] FAIL wd_main_mute got %b/%0d/%0d want 0/0/0", active, sample_L, sample_R); end
    send_frame(mk(3, 10'h100, 0), 16, 0, 1, "wd_main_restore");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_held();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
